// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch front end with prefetch FIFO and redirect flush
//
// Purpose:
//   Owns the PC and issues in-order requests to instruction memory, keeping the
//   number of in-flight requests plus buffered words within DEPTH. Returned words
//   are buffered with their PC and presented to the core with a valid/ready
//   handshake. A redirect restarts fetch at a new PC, flushes the buffer and
//   discards responses that are still in flight.
//
// Ports:
//   CLK, Reset          clock, synchronous active-high reset
//   imem_req/addr/gnt   request channel to instruction memory
//   imem_rvalid/rdata   in-order response channel
//   Instr/InstrPC       head-of-FIFO instruction and its PC (0 when empty)
//   instr_valid/ready   handshake to the core
//   redirect/_pc        one-cycle restart pulse and target PC
//
// Optional feature (macro IFU_PERF_CNT_EN):
//   stall_cycles        saturating count of RUN cycles with no instruction offered
//   flush_count         saturating count of redirect pulses

module instr_fetch_unit #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] Instr,
    output logic [ADDR_W-1:0] InstrPC,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]       DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;

    // Prefetch FIFO of {PC, word}
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] word_mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    // PC of every accepted request, popped by every response (kept or dropped)
    logic [ADDR_W-1:0] tag_mem  [DEPTH];
    logic [PW-1:0]     tag_wr;
    logic [PW-1:0]     tag_rd;

    logic [CW-1:0]     pend;
    logic [CW-1:0]     drop;

    logic credit_ok;
    logic accept;
    logic resp;
    logic push;
    logic pop;

    // Credit counts both buffered words and in-flight requests, so a response
    // always has a FIFO slot waiting for it.
    assign credit_ok   = ({1'b0, count} + {1'b0, pend}) < DEPTH_W;
    assign imem_req    = !Reset && !redirect && (state == RUN) && credit_ok;
    assign imem_addr   = fetch_pc;
    assign instr_valid = !Reset && (state == RUN) && (count != '0);
    assign Instr       = (count != '0) ? word_mem[rd_ptr] : '0;
    assign InstrPC     = (count != '0) ? pc_mem[rd_ptr]   : '0;

    assign accept = imem_req && imem_gnt;
    assign resp   = !Reset && imem_rvalid && (pend != '0);
    // A response in the redirect cycle belongs to the old stream and is dropped.
    assign push   = resp && (state == RUN) && !redirect && (drop == '0);
    assign pop    = instr_valid && instr_ready;

    // Storage arrays need no reset; occupancy is tracked by the pointers.
    always_ff @(posedge CLK) begin
        if (accept) begin
            tag_mem[tag_wr] <= fetch_pc;
        end
        if (push) begin
            pc_mem[wr_ptr]   <= tag_mem[tag_rd];
            word_mem[wr_ptr] <= imem_rdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tag_wr   <= '0;
            tag_rd   <= '0;
            pend     <= '0;
            drop     <= '0;
        end else begin
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (accept) begin
                fetch_pc <= fetch_pc + STEP;
            end

            if (accept) begin
                tag_wr <= tag_wr + PW'(1);
            end
            if (resp) begin
                tag_rd <= tag_rd + PW'(1);
            end
            pend <= pend + CW'(accept) - CW'(resp);

            case (state)
                RUN: begin
                    if (redirect) begin
                        count  <= '0;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        drop   <= pend - CW'(resp);
                        state  <= (pend != CW'(resp)) ? FLUSH : RUN;
                    end else begin
                        if (push) begin
                            wr_ptr <= wr_ptr + PW'(1);
                        end
                        if (pop) begin
                            rd_ptr <= rd_ptr + PW'(1);
                        end
                        count <= count + CW'(push) - CW'(pop);
                    end
                end
                FLUSH: begin
                    // No requests are issued here, so a redirect only moves fetch_pc.
                    if (drop == '0) begin
                        state <= RUN;
                    end else if (resp) begin
                        drop <= drop - CW'(1);
                        if (drop == CW'(1)) begin
                            state <= RUN;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (Reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if ((state == RUN) && !instr_valid && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (redirect && (flush_count != '1)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`else
    // Counters absent in this build.
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    instr_fetch_unit #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)
    ) dut (
        .CLK(CLK), .Reset(Reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .Instr(Instr), .InstrPC(InstrPC),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef IFU_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, want, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'hA5A5_5A5A) + 32'h0001_3579;
    endfunction

    // ---------------- memory model + scoreboard ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] sb_q[$];
    int          m_count = 0;
    int          m_drop = 0;
    logic [31:0] m_fetch_pc = '0;
    int          cyc = 0;
    int          lat = 1;

    initial begin
        logic        nrv;
        logic [31:0] nrd;
        logic        rsp, acc, pp, want_req;
        int          m_pend;
        forever begin
            @(negedge CLK);
            cyc++;
            nrv = 1'b0;
            nrd = '0;
            if (Reset) begin
                mem_q.delete();
                sb_q.delete();
                m_count    = 0;
                m_drop     = 0;
                m_fetch_pc = '0;
            end else begin
                want_req = !redirect && (m_drop == 0) && (sb_q.size() < DEPTH);
                check("imem_req", 32'(imem_req), 32'(want_req));
                if (imem_req) check("imem_addr", imem_addr, m_fetch_pc);
                check("instr_valid", 32'(instr_valid), 32'((m_drop == 0) && (m_count > 0)));
                if (m_count > 0 && sb_q.size() > 0) begin
                    check("sb_pc", InstrPC, sb_q[0]);
                    check("sb_word", Instr, mem_word(sb_q[0]));
                end else begin
                    check("empty_pc", InstrPC, 32'h0);
                    check("empty_word", Instr, 32'h0);
                end
                rsp    = imem_rvalid;
                acc    = imem_req && imem_gnt;
                pp     = instr_valid && instr_ready;
                m_pend = mem_q.size();
                if (rsp) begin
                    check("rvalid_with_pend", 32'(dut.pend != '0), 32'h1);
                    if (mem_q.size() > 0) void'(mem_q.pop_front());
                end
                if (redirect) begin
                    if (m_drop == 0) begin
                        sb_q.delete();
                        m_count = 0;
                        m_drop  = m_pend - (rsp ? 1 : 0);
                    end else if (rsp) begin
                        m_drop--;
                    end
                    m_fetch_pc = redirect_pc;
                end else begin
                    if (pp && m_count > 0) begin
                        void'(sb_q.pop_front());
                        m_count--;
                    end
                    if (rsp) begin
                        if (m_drop > 0) m_drop--;
                        else m_count++;
                    end
                    if (acc) begin
                        sb_q.push_back(m_fetch_pc);
                        m_fetch_pc = m_fetch_pc + 32'd4;
                    end
                end
                if (acc) mem_q.push_back('{addr: imem_addr, due: cyc + lat});
                if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1) begin
                    nrv = 1'b1;
                    nrd = mem_word(mem_q[0].addr);
                end
            end
            @(posedge CLK);
            #1;
            imem_rvalid = nrv;
            imem_rdata  = nrd;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Leaves the bench at the start of the first cycle after reset release.
    task automatic do_reset();
        Reset       = 1'b1;
        redirect    = 1'b0;
        imem_gnt    = 1'b0;
        instr_ready = 1'b0;
        step();
        @(negedge CLK);
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_instr", Instr, 32'h0);
        check("rst_pc", InstrPC, 32'h0);
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input logic [31:0] pc);
        int k;
        k = 0;
        @(negedge CLK);
        while (!instr_valid && k < 30) begin
            @(negedge CLK);
            k++;
        end
        if (!instr_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: timeout waiting for instr_valid, want pc %h", nm, pc);
        end else begin
            check(nm, InstrPC, pc);
        end
    endtask

    // Two requests in flight with latency 3, redirect to tgt; returns at
    // the negedge of the first FLUSH cycle.
    task automatic flush2(input logic [31:0] tgt);
        lat = 3;
        do_reset();
        imem_gnt    = 1'b1;
        instr_ready = 1'b1;
        step();
        step();
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = tgt;
        step();
        redirect = 1'b0;
        @(negedge CLK);
        check("flush_state", 32'(dut.state), 32'h1);
        check("flush_drop", 32'(dut.drop), 32'h2);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        ready;
        logic        gnt;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic        chk_cnt;
        logic [31:0] cnt;
    } vec_t;

    localparam int NV = 17;
    vec_t tv[NV];

    function automatic vec_t mk(logic rst, logic ready, logic gnt, logic req, logic [31:0] addr,
                                logic valid, logic [31:0] pc, logic chk_cnt, logic [31:0] cnt);
        vec_t v;
        v.rst = rst; v.ready = ready; v.gnt = gnt; v.req = req; v.addr = addr;
        v.valid = valid; v.pc = pc; v.chk_cnt = chk_cnt; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        // streaming, latency 1, ready held high
        tv[0]  = mk(1, 1, 1, 1, 32'd0,  0, 32'd0,  0, 0);
        tv[1]  = mk(0, 1, 1, 1, 32'd4,  0, 32'd0,  0, 0);
        tv[2]  = mk(0, 1, 1, 1, 32'd8,  1, 32'd0,  0, 0);
        tv[3]  = mk(0, 1, 1, 1, 32'd12, 1, 32'd4,  0, 0);
        tv[4]  = mk(0, 1, 1, 1, 32'd16, 1, 32'd8,  0, 0);
        tv[5]  = mk(0, 1, 1, 1, 32'd20, 1, 32'd12, 0, 0);
        // back-pressure: four grants then credit exhausted, then drain
        tv[6]  = mk(1, 0, 1, 1, 32'd0,  0, 32'd0,  0, 0);
        tv[7]  = mk(0, 0, 1, 1, 32'd4,  0, 32'd0,  0, 0);
        tv[8]  = mk(0, 0, 1, 1, 32'd8,  1, 32'd0,  0, 0);
        tv[9]  = mk(0, 0, 1, 1, 32'd12, 1, 32'd0,  0, 0);
        tv[10] = mk(0, 0, 1, 0, 32'd0,  1, 32'd0,  0, 0);
        tv[11] = mk(0, 0, 1, 0, 32'd0,  1, 32'd0,  1, 4);
        tv[12] = mk(0, 1, 1, 0, 32'd0,  1, 32'd0,  1, 4);
        tv[13] = mk(0, 1, 1, 1, 32'd16, 1, 32'd4,  0, 0);
        tv[14] = mk(0, 1, 1, 1, 32'd20, 1, 32'd8,  0, 0);
        tv[15] = mk(0, 1, 1, 1, 32'd24, 1, 32'd12, 0, 0);
        tv[16] = mk(0, 1, 1, 1, 32'd28, 1, 32'd16, 0, 0);

        for (int i = 0; i < NV; i++) begin
            if (tv[i].rst) begin
                lat = 1;
                do_reset();
            end
            instr_ready = tv[i].ready;
            imem_gnt    = tv[i].gnt;
            @(negedge CLK);
            check($sformatf("t%0d_req", i), 32'(imem_req), 32'(tv[i].req));
            if (tv[i].req) check($sformatf("t%0d_addr", i), imem_addr, tv[i].addr);
            check($sformatf("t%0d_valid", i), 32'(instr_valid), 32'(tv[i].valid));
            check($sformatf("t%0d_pc", i), InstrPC, tv[i].pc);
            if (tv[i].chk_cnt) check($sformatf("t%0d_count", i), 32'(dut.count), tv[i].cnt);
            step();
        end

        // redirect with two stale responses in flight
        flush2(32'h100);
        imem_gnt = 1'b1;
        step();
        @(negedge CLK);
        check("flush_hold", 32'(dut.state), 32'h1);
        step();
        @(negedge CLK);
        check("flush_exit", 32'(dut.state), 32'h0);
        check("resume_addr", imem_addr, 32'h100);
        step();
        wait_valid("redir_pc0", 32'h100);
        step();
        @(negedge CLK);
        check("redir_pc1", InstrPC, 32'h104);

        // redirect coinciding with the only outstanding response
        lat = 2;
        do_reset();
        imem_gnt    = 1'b1;
        instr_ready = 1'b1;
        step();
        imem_gnt = 1'b0;
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        imem_gnt    = 1'b1;
        @(negedge CLK);
        check("coinc_pend", 32'(dut.pend), 32'h1);
        step();
        redirect = 1'b0;
        @(negedge CLK);
        check("coinc_state", 32'(dut.state), 32'h0);
        check("coinc_drop", 32'(dut.drop), 32'h0);
        check("coinc_req", 32'(imem_req), 32'h1);
        check("coinc_addr", imem_addr, 32'h200);
        check("coinc_novalid", 32'(instr_valid), 32'h0);
        wait_valid("coinc_pc", 32'h200);

        // reset in the middle of FLUSH
        flush2(32'h300);
        #1;
        Reset = 1'b1;
        step();
        @(negedge CLK);
        check("rflush_state", 32'(dut.state), 32'h0);
        check("rflush_fpc", dut.fetch_pc, 32'h0);
        check("rflush_valid", 32'(instr_valid), 32'h0);
        check("rflush_pend", 32'(dut.pend), 32'h0);
        step();
        Reset = 1'b0;

`ifdef IFU_PERF_CNT_EN
        lat = 1;
        do_reset();
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect_pc = 32'h80;
        step();
        redirect_pc = 32'hC0;
        step();
        redirect = 1'b0;
        step();
        step();
        @(negedge CLK);
        check("perf_flush", flush_count, 32'd3);
        check("perf_stall", stall_cycles, 32'd5);
`endif

        // randomised traffic, checked by the scoreboard
        for (int l = 1; l <= 3; l++) begin
            lat = l;
            do_reset();
            for (int c = 0; c < 400; c++) begin
                imem_gnt    = ($urandom_range(0, 3) != 0);
                instr_ready = ($urandom_range(0, 3) != 0);
                redirect    = ($urandom_range(0, 24) == 0);
                redirect_pc = 32'($urandom_range(0, 1023)) << 2;
                step();
            end
            redirect = 1'b0;
            repeat (8) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
